// File: rtl/arbitro_barrera.sv
// Barrier-lane arbiter for the parking lot: grants entry/exit round-robin,
// refuses entry when full and sequences the barrier open/hold/close.
module arbitro_barrera #(
    parameter int unsigned CAPACIDAD = 7,
    parameter int unsigned T_MOV     = 50,
    parameter int unsigned T_ESPERA  = 500,
    parameter int unsigned W_TMR     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_in,
    input  logic       req_out,
    input  logic [2:0] autos,
    input  logic       entrada,
    input  logic       salida,
    output logic       barrera_abrir,
    output logic       gnt_in,
    output logic       gnt_out,
    output logic       ocupado,
    output logic       lleno,
    output logic       timeout,
    output logic       error_seq
);

    typedef enum logic [1:0] {StIdle, StAbriendo, StAbierta, StCerrando} estado_e;

    localparam logic [2:0]       Cap     = 3'(CAPACIDAD);
    localparam logic [W_TMR-1:0] MovLast = W_TMR'(T_MOV - 1);
    localparam logic [W_TMR-1:0] EspLast = W_TMR'(T_ESPERA - 1);

    estado_e          estado_q;
    logic [W_TMR-1:0] tmr_q;
    logic             ultimo_q;  // 1: last grant went to the exit lane

    logic ok_in, ok_out, pick_out, match, mismatch;

    always_comb begin
        ok_in    = req_in & (autos < Cap);
        ok_out   = req_out & (autos != 3'd0);
        // On a tie the lane opposite to the last grant wins
        pick_out = ok_out & (~ok_in | ~ultimo_q);
        match    = (entrada & gnt_in) | (salida & gnt_out);
        mismatch = (entrada & gnt_out) | (salida & gnt_in);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q      <= StIdle;
            tmr_q         <= '0;
            ultimo_q      <= 1'b1;
            barrera_abrir <= 1'b0;
            gnt_in        <= 1'b0;
            gnt_out       <= 1'b0;
            ocupado       <= 1'b0;
            lleno         <= 1'b0;
            timeout       <= 1'b0;
            error_seq     <= 1'b0;
        end else begin
            lleno   <= (autos >= Cap);
            timeout <= 1'b0;
            if (mismatch) begin
                error_seq <= 1'b1;
            end
            unique case (estado_q)
                StIdle: begin
                    if (ok_in || ok_out) begin
                        estado_q      <= StAbriendo;
                        tmr_q         <= '0;
                        gnt_in        <= ~pick_out;
                        gnt_out       <= pick_out;
                        ultimo_q      <= pick_out;
                        barrera_abrir <= 1'b1;
                        ocupado       <= 1'b1;
                    end
                end
                StAbriendo, StAbierta: begin
                    // A car may pass before the barrier is fully open
                    if (match) begin
                        estado_q      <= StCerrando;
                        tmr_q         <= '0;
                        barrera_abrir <= 1'b0;
                    end else if (estado_q == StAbriendo && tmr_q == MovLast) begin
                        estado_q <= StAbierta;
                        tmr_q    <= '0;
                    end else if (estado_q == StAbierta && tmr_q == EspLast) begin
                        estado_q      <= StCerrando;
                        tmr_q         <= '0;
                        barrera_abrir <= 1'b0;
                        timeout       <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q + W_TMR'(1);
                    end
                end
                StCerrando: begin
                    if (tmr_q == MovLast) begin
                        estado_q <= StIdle;
                        tmr_q    <= '0;
                        gnt_in   <= 1'b0;
                        gnt_out  <= 1'b0;
                        ocupado  <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q + W_TMR'(1);
                    end
                end
                default: estado_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_barrera.sv
// Self-checking bench for arbitro_barrera: grant directions go through a
// scoreboard queue, phase timing and flags are checked against fixed values.
module tb_arbitro_barrera;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_in, req_out, entrada, salida;
    logic [2:0] autos;
    logic       barrera_abrir, gnt_in, gnt_out, ocupado, lleno, timeout, error_seq;

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_q[$];  // expected grant direction, 1 = exit lane
    bit e_dir;
    logic gnt_prev = 1'b0;

    arbitro_barrera #(
        .CAPACIDAD(7),
        .T_MOV    (4),
        .T_ESPERA (16),
        .W_TMR    (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_in       (req_in),
        .req_out      (req_out),
        .autos        (autos),
        .entrada      (entrada),
        .salida       (salida),
        .barrera_abrir(barrera_abrir),
        .gnt_in       (gnt_in),
        .gnt_out      (gnt_out),
        .ocupado      (ocupado),
        .lleno        (lleno),
        .timeout      (timeout),
        .error_seq    (error_seq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Stimulus acts 2 time units after the edge; the monitor samples at 1
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: each new grant pops the expected direction
    always @(posedge clk) begin
        #1;
        if (!rst && (gnt_in || gnt_out) && !gnt_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_gnt", exp_q.size(), 1);
            end else begin
                e_dir = exp_q.pop_front();
                chk("gnt_dir", {31'd0, gnt_out}, {31'd0, e_dir});
                chk("gnt_excl", {31'd0, gnt_in & gnt_out}, 0);
            end
        end
        gnt_prev = rst ? 1'b0 : (gnt_in | gnt_out);
    end

    task automatic wait_gnt(input string tag);
        int n = 0;
        while (!(gnt_in || gnt_out) && n < 60) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, gnt_in | gnt_out}, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (ocupado && n < 60) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, ocupado}, 0);
    endtask

    task automatic pulse(input bit out_dir);
        if (out_dir) salida = 1'b1;
        else entrada = 1'b1;
        tick();
        entrada = 1'b0;
        salida  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {25'd0, barrera_abrir, gnt_in, gnt_out, ocupado, lleno, timeout, error_seq}, 0);
    endtask

    initial begin
        rst = 1'b1; req_in = 0; req_out = 0; entrada = 0; salida = 0; autos = 3'd0;
        tick();
        tick();
        chk("rst_barrera", {31'd0, barrera_abrir}, 0);
        chk("rst_gnt_in", {31'd0, gnt_in}, 0);
        chk("rst_gnt_out", {31'd0, gnt_out}, 0);
        chk("rst_ocupado", {31'd0, ocupado}, 0);
        chk("rst_flags", {29'd0, lleno, timeout, error_seq}, 0);
        rst = 1'b0;

        // 1: basic entry transaction
        autos = 3'd2; req_in = 1; exp_q.push_back(1'b0);
        tick();
        req_in = 0;
        chk("t1_gnt_in", {31'd0, gnt_in}, 1);
        chk("t1_abrir", {31'd0, barrera_abrir}, 1);
        chk("t1_ocupado", {31'd0, ocupado}, 1);
        for (int i = 0; i < 4; i++) tick();
        chk("t1_open_hold", {31'd0, barrera_abrir}, 1);
        pulse(1'b0);
        chk("t1_closing", {30'd0, barrera_abrir, gnt_in}, 1);
        for (int i = 0; i < 3; i++) tick();
        chk("t1_still_busy", {31'd0, ocupado}, 1);
        tick();
        chk("t1_idle", {30'd0, ocupado, gnt_in}, 0);

        // 2: round-robin with both lanes held
        rst = 1; tick(); rst = 0;
        autos = 3'd3; req_in = 1; req_out = 1;
        exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_gnt("t2_gnt");
            if (i == 2) begin
                req_in = 0;
                req_out = 0;
            end
            pulse(i % 2 == 1);
            wait_idle("t2_idle");
        end

        // 3: full lot refuses entry but serves exit
        autos = 3'd7; req_in = 1;
        tick();
        tick();
        chk("t3_lleno", {31'd0, lleno}, 1);
        tick();
        chk("t3_no_grant", {30'd0, ocupado, gnt_in}, 0);
        req_out = 1; exp_q.push_back(1'b1);
        wait_gnt("t3_gnt");
        chk("t3_gnt_out", {31'd0, gnt_out}, 1);
        req_in = 0; req_out = 0;
        pulse(1'b1);
        wait_idle("t3_idle");

        // 4: empty lot refuses exit
        autos = 3'd0; req_out = 1;
        tick(); tick(); tick();
        chk("t4_no_grant", {30'd0, ocupado, lleno}, 0);
        req_in = 1; exp_q.push_back(1'b0);
        wait_gnt("t4_gnt");
        chk("t4_gnt_in", {31'd0, gnt_in}, 1);
        req_in = 0; req_out = 0;
        pulse(1'b0);
        wait_idle("t4_idle");

        // 5: hold window expires (4 opening + 16 held cycles)
        autos = 3'd2; req_in = 1; exp_q.push_back(1'b0);
        tick();
        req_in = 0;
        for (int i = 0; i < 19; i++) tick();
        chk("t5_before_to", {30'd0, timeout, barrera_abrir}, 1);
        tick();
        chk("t5_timeout", {30'd0, timeout, barrera_abrir}, 2);
        tick();
        chk("t5_to_pulse", {31'd0, timeout}, 0);
        chk("t5_no_err", {31'd0, error_seq}, 0);
        wait_idle("t5_idle");

        // 6: wrong-direction pulse, then reset mid-opening
        req_in = 1; exp_q.push_back(1'b0);
        tick();
        req_in = 0;
        for (int i = 0; i < 4; i++) tick();
        pulse(1'b1);
        chk("t6_err", {29'd0, error_seq, barrera_abrir, gnt_in}, 7);
        pulse(1'b0);
        chk("t6_close", {31'd0, barrera_abrir}, 0);
        wait_idle("t6_idle");
        chk("t6_sticky", {31'd0, error_seq}, 1);
        req_in = 1; exp_q.push_back(1'b0);
        tick();
        req_in = 0;
        tick();
        chk("t6_opening", {31'd0, barrera_abrir}, 1);
        rst = 1;
        #1;
        chk_all_zero("t6_async_rst");
        tick();
        rst = 0;
        tick();
        chk_all_zero("t6_after_rst");
        chk("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
